acc_sub_fix: RTL and testbench

Streaming saturating fixed-point add/subtract accumulator for the MNIST inference datapath. Each beat adds or subtracts a signed W-bit operand into a running sum, and the sum is clamped every beat to the codebase's symmetric fixed-point range ±(2^(W-1)-1). It sits after the multiplier/adder array and turns a frame of partial terms into one neuron pre-activation. A valid/ready handshake is used on both sides.

---
 rtl/fix_pkg.sv | 14 +
 rtl/sat_addsub_fix.sv | 31 +++
 rtl/acc_sub_fix.sv | 74 +++++++
 tb/tb_acc_sub_fix.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// fix_pkg: shared symmetric fixed-point limits and accumulator FSM states
package fix_pkg;

    typedef enum logic {ACC, OUT} acc_state_t;

    function automatic int fix_max(int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int fix_min(int w);
        return -((1 << (w - 1)) - 1);
    endfunction

endpackage

// File: rtl/sat_addsub_fix.sv
// sat_addsub_fix: combinational a +/- b clamped to the symmetric W-bit range
module sat_addsub_fix
    import fix_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                sub,
    output logic signed [W-1:0] y,
    output logic                sat
);

    localparam logic signed [W+1:0] MAX_X = (W + 2)'(fix_max(W));
    localparam logic signed [W+1:0] MIN_X = (W + 2)'(fix_min(W));
    localparam logic signed [W-1:0] MAX_V = W'(fix_max(W));
    localparam logic signed [W-1:0] MIN_V = W'(fix_min(W));

    logic signed [W+1:0] ax, bx, raw;

    assign ax = {{2{a[W-1]}}, a};
    assign bx = {{2{b[W-1]}}, b};

    // Two guard bits keep the widened sum exact before the clamp; -2^(W-1) is never emitted
    always_comb begin
        raw = sub ? ax - bx : ax + bx;
        sat = (raw > MAX_X) || (raw < MIN_X);
        y   = raw > MAX_X ? MAX_V : raw < MIN_X ? MIN_V : raw[W-1:0];
    end

endmodule

// File: rtl/acc_sub_fix.sv
// acc_sub_fix: streaming saturating add/subtract accumulator emitting one result per frame
module acc_sub_fix
    import fix_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    input  logic                in_sub,
    input  logic                in_first,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_sat
);

    acc_state_t          state, state_nxt;
    logic signed [W-1:0] acc, base, sum;
    logic                sat_flag, beat_sat, sat_upd, accept, take;

    assign in_ready = (state == ACC);
    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;
    assign base     = in_first ? '0 : acc;
    assign sat_upd  = (in_first ? 1'b0 : sat_flag) | beat_sat;

    sat_addsub_fix #(.W(W)) u_addsub (
        .a   (base),
        .b   (in_data),
        .sub (in_sub),
        .y   (sum),
        .sat (beat_sat)
    );

    // Move to OUT on the accepted last beat, back to ACC once the result is taken
    always_comb begin
        state_nxt = state;
        if (state == ACC && accept && in_last) state_nxt = OUT;
        if (state == OUT && take) state_nxt = ACC;
    end

    // Accumulator, sticky saturation flag and registered result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc      <= sum;
                sat_flag <= sat_upd;
                if (in_last) begin
                    out_data  <= sum;
                    out_sat   <= sat_upd;
                    out_valid <= 1'b1;
                end
            end
            if (take) begin
                out_valid <= 1'b0;
                acc       <= '0;
                sat_flag  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acc_sub_fix.sv
// tb_acc_sub_fix: directed self-checking bench for acc_sub_fix at W=4
module tb_acc_sub_fix;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [3:0] in_data = '0;
    logic              in_sub = 1'b0;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [3:0] out_data;
    logic              out_sat;

    int checks = 0;
    int errors = 0;

    acc_sub_fix #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic beat(input logic signed [3:0] d, input logic s, input logic f, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        in_first = f;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'sd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b data=%0d sat=%b ready=%b, want 0 0 0 1", out_valid, out_data, out_sat, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        beat(4'sd3, 1'b0, 1'b1, 1'b0);
        beat(4'sd2, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: valid=%b, want 0", out_valid);
        end
        beat(4'sd1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'sd4 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic: valid=%b data=%0d sat=%b, want 1 4 0", out_valid, out_data, out_sat);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready: ready=%b, want 0", in_ready);
        end
        take_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_take: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_no_first();
        beat(4'sd2, 1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'sd2 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL no_first: valid=%b data=%0d sat=%b, want 1 2 0", out_valid, out_data, out_sat);
        end
        take_result();
    endtask

    task automatic test_running_sat();
        beat(4'sd7, 1'b0, 1'b1, 1'b0);
        beat(4'sd1, 1'b0, 1'b0, 1'b0);
        beat(4'sd3, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'sd4 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL running_sat: valid=%b data=%0d sat=%b, want 1 4 1", out_valid, out_data, out_sat);
        end
        take_result();
    endtask

    task automatic test_extremes();
        beat(-4'sd8, 1'b1, 1'b1, 1'b1);
        checks++;
        if (out_data !== 4'sd7 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sub_min: data=%0d sat=%b, want 7 1", out_data, out_sat);
        end
        take_result();
        beat(-4'sd8, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_data !== -4'sd7 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL add_min: data=%0d sat=%b, want -7 1", out_data, out_sat);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        beat(4'sd5, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 4'sd3;
            in_first = 1'b1;
            in_last  = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'sd5 || out_sat !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b data=%0d sat=%b ready=%b, want 1 5 0 0", i, out_valid, out_data, out_sat, in_ready);
            end
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        take_result();
        beat(4'sd1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'sd1 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL after_bp: valid=%b data=%0d sat=%b, want 1 1 0", out_valid, out_data, out_sat);
        end
        take_result();
    endtask

    task automatic test_first_midframe();
        beat(4'sd5, 1'b0, 1'b1, 1'b0);
        beat(4'sd2, 1'b0, 1'b0, 1'b0);
        beat(4'sd1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'sd1 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL first_mid: valid=%b data=%0d sat=%b, want 1 1 0", out_valid, out_data, out_sat);
        end
        take_result();
    endtask

    task automatic test_reset_midframe();
        beat(4'sd5, 1'b0, 1'b1, 1'b0);
        beat(4'sd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'sd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b data=%0d sat=%b ready=%b, want 0 0 0 1", out_valid, out_data, out_sat, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        beat(4'sd1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'sd1 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: valid=%b data=%0d sat=%b, want 1 1 0", out_valid, out_data, out_sat);
        end
        take_result();
    endtask

    task automatic test_reset_in_out();
        beat(4'sd6, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'sd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%0d ready=%b, want 0 0 1", out_valid, out_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_first();
        test_running_sat();
        test_extremes();
        test_backpressure();
        test_first_midframe();
        test_reset_midframe();
        test_reset_in_out();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
